// File: rtl/demux_stream_slot.sv
// One-entry output register for a single demux channel.
// Holds its word until drained; a load and drain in the same cycle replaces the word with no bubble.
module demux_stream_slot #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);

    assign free = !valid || drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_nway_stream_chip.sv
// Registered N-way valid/ready stream demux with broadcast and per-channel output slots.
// Out-of-range selects are accepted and dropped, flagged by a one-cycle sel_err pulse.
module demux_nway_stream_chip #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned N     = 8,
    parameter int unsigned SELW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic                 sel_err,
    output logic [15:0]          xfer_count
);

    if ((1 << SELW) < N) begin : g_bad_selw
        $error("demux_nway_stream_chip: SELW too narrow for N");
    end
    if (N < 2 || N > 16) begin : g_bad_n
        $error("demux_nway_stream_chip: N must be in 2..16");
    end

    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         sel_free;
    logic         accept;

    assign sel_ok = 32'(in_sel) < N;

    // Index free[] only over legal channels so an out-of-range select never reads past N.
    always_comb begin
        sel_free = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_sel == SELW'(i)) begin
                sel_free = free[i];
            end
        end
    end

    assign in_ready = in_bcast ? &free : (sel_ok ? sel_free : 1'b1);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign load[i] = accept && (in_bcast || in_sel == SELW'(i));

        demux_stream_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[i]),
            .load_data (in_data),
            .drain     (out_ready[i]),
            .data      (out_data[i*WIDTH +: WIDTH]),
            .valid     (out_valid[i]),
            .free      (free[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err    <= 1'b0;
            xfer_count <= 16'h0000;
        end else begin
            sel_err <= accept && !in_bcast && !sel_ok;
            if (accept) begin
                xfer_count <= xfer_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_demux_nway_stream_chip.sv
// Scoreboard bench: driver pushes expected words per channel, a negedge monitor pops on takes.
module tb_demux_nway_stream_chip;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 6;
    localparam int unsigned SELW  = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [WIDTH-1:0]     in_data = '0;
    logic [SELW-1:0]      in_sel = '0;
    logic                 in_bcast = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready = '0;
    logic                 sel_err;
    logic [15:0]          xfer_count;

    demux_nway_stream_chip #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel_err    (sel_err),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Reference model: expected words per channel, occupancy, error flag, transfer count.
    logic [WIDTH-1:0] exp_q [N][$];
    bit               occ [N];
    bit               exp_err = 1'b0;
    logic [15:0]      exp_cnt = 16'h0000;
    bit               last_acc = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: judge acceptance from the model at negedge, update the model at the edge.
    task automatic step();
        bit exp_ready;
        bit all_free;
        bit acc;
        @(negedge clk);
        all_free = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (occ[i] && !out_ready[i]) all_free = 1'b0;
        end
        if (in_bcast) exp_ready = all_free;
        else if (int'(in_sel) < N) exp_ready = !occ[in_sel] || out_ready[in_sel];
        else exp_ready = 1'b1;
        if (!reset) check("in_ready", 64'(in_ready), 64'(exp_ready));
        acc = in_valid && exp_ready && !reset;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (acc && (in_bcast || int'(in_sel) == i)) begin
                    occ[i] = 1'b1;
                    exp_q[i].push_back(in_data);
                end else if (out_ready[i]) begin
                    occ[i] = 1'b0;
                end
            end
            exp_err = acc && !in_bcast && int'(in_sel) >= N;
            if (acc) exp_cnt = exp_cnt + 16'h0001;
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input int sel, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        in_bcast = 1'b0;
        in_sel   = SELW'(sel);
        in_data  = data;
        step();
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            occ[i] = 1'b0;
        end
        exp_err = 1'b0;
        exp_cnt = 16'h0000;
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        reset    = 1'b1;
        model_clear();
        #1;
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_sel_err"}, 64'(sel_err), 64'(0));
        check({tag, "_xfer_count"}, 64'(xfer_count), 64'(0));
        step();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]),
                      64'(exp_q[i].size() != 0));
                if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0) begin
                    check($sformatf("out_data[%0d]", i), 64'(out_data[i*WIDTH +: WIDTH]),
                          64'(exp_q[i].pop_front()));
                end
            end
            check("sel_err", 64'(sel_err), 64'(exp_err));
            check("xfer_count", 64'(xfer_count), 64'(exp_cnt));
        end
    end

    initial begin
        model_clear();
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_sel_err", 64'(sel_err), 64'(0));
        check("rst_xfer_count", 64'(xfer_count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sweep every legal channel with all consumers ready.
        out_ready = '1;
        for (int k = 0; k < N; k++) begin
            send(k, 8'h01);
            check("sweep_valid", 64'(out_valid), 64'(1 << k));
        end
        in_valid = 1'b0;
        step();
        check("sweep_count", 64'(xfer_count), 64'(N));

        // Stall isolation on channel 3.
        out_ready = 6'b110111;
        send(3, 8'hA5);
        in_data = 8'h5A;
        #1;
        check("stall_in_ready", 64'(in_ready), 64'(0));
        step();
        step();
        check("stall_hold", 64'(out_data[3*WIDTH +: WIDTH]), 64'(8'hA5));
        out_ready = '1;
        step();
        check("stall_next", 64'(out_data[3*WIDTH +: WIDTH]), 64'(8'h5A));
        send(4, 8'h11);
        check("stall_ch4", 64'(out_data[4*WIDTH +: WIDTH]), 64'(8'h11));

        // Broadcast blocked by a stalled channel 5, then released.
        out_ready = 6'b011111;
        send(5, 8'h77);
        in_bcast = 1'b1;
        in_data  = 8'h3C;
        #1;
        check("bcast_blocked", 64'(in_ready), 64'(0));
        step();
        check("bcast_no_load", 64'(out_valid), 64'(6'b100000));
        out_ready = '1;
        step();
        check("bcast_valid", 64'(out_valid), 64'(6'b111111));
        check("bcast_data", 64'(out_data), 64'({6{8'h3C}}));
        in_bcast = 1'b0;

        // Out-of-range select is accepted and dropped.
        send(7, 8'h99);
        in_valid = 1'b0;
        check("oor_sel_err", 64'(sel_err), 64'(1));
        check("oor_no_valid", 64'(out_valid), 64'(0));
        check("oor_count", 64'(xfer_count), 64'(16'h000C));
        step();
        check("oor_pulse_end", 64'(sel_err), 64'(0));

        // Same-cycle load and drain on channel 2.
        for (int w = 0; w < 4; w++) begin
            send(2, 8'hD0 + 8'(w));
            check("ld_valid", 64'(out_valid[2]), 64'(1));
            check("ld_data", 64'(out_data[2*WIDTH +: WIDTH]), 64'(8'hD0 + 8'(w)));
        end
        in_valid = 1'b0;
        step();

        // Random traffic; inputs are held while a presented word is stalled.
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_bcast = ($urandom_range(0, 7) == 0);
                in_sel   = SELW'($urandom_range(0, 7));
                in_data  = WIDTH'($urandom);
            end
            out_ready = N'($urandom);
            step();
        end

        // Fill three channels and reach a count of 0x42, then reset mid-stream.
        async_reset("pre");
        out_ready = '0;
        for (int k = 0; k < 3; k++) send(k, 8'hE0 + 8'(k));
        for (int k = 0; k < 63; k++) send(7, 8'h00);
        in_valid = 1'b0;
        check("mid_count", 64'(xfer_count), 64'(16'h0042));
        check("mid_full", 64'(out_valid), 64'(6'b000111));
        async_reset("mid");
        step();
        check("mid_no_pulse", 64'(out_valid), 64'(0));

        // Counter wrap.
        out_ready = '1;
        in_valid  = 1'b1;
        in_bcast  = 1'b0;
        in_sel    = SELW'(7);
        for (int k = 0; k < 65535; k++) step();
        check("wrap_ffff", 64'(xfer_count), 64'(16'hFFFF));
        step();
        in_valid = 1'b0;
        check("wrap_zero", 64'(xfer_count), 64'(16'h0000));
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_nway_stream_chip.md
# demux_nway_stream_chip

Parametrised, registered successor to the combinational 8-way 1-bit demux. It routes a WIDTH-bit word from a single valid/ready input stream to one of N output channels, or to all N at once. Each channel has a one-entry output register, so a stalled channel holds its own data without blocking the other channels. It sits between the instruction/data fabric and N downstream consumers that may stall independently.

## Interface
Parameters:
- WIDTH, default 1: data bits per word.
- N, default 8: number of output channels, legal range 2..16.
- SELW, default 3: select width. Must satisfy 2^SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  target channel index.
- in_bcast  input  1  1 = deliver to all N channels; in_sel is ignored.
- in_valid  input  1  input word is present.
- in_ready  output  1  input can be accepted this cycle. Combinational.
- out_data  output  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  N  channel i holds a word.
- out_ready  input  N  consumer i takes its word this cycle.
- sel_err  output  1  one-cycle pulse when a word with in_sel >= N was accepted and dropped.
- xfer_count  output  16  count of accepted input words, including dropped ones.

## Operation
- Channel i is free when !out_valid[i] || out_ready[i].
- in_ready is set by mode:
  - in_bcast=1: AND of free[0..N-1].
  - in_bcast=0 and in_sel<N: free[in_sel].
  - in_bcast=0 and in_sel>=N: 1 (the word is discarded).
- Accept: in_valid && in_ready.
- Per-channel update:
  - Channel i is loaded on accept when in_bcast=1, or when in_sel==i with in_sel<N. A load sets out_data[i]=in_data and out_valid[i]=1.
  - If channel i is not loaded and out_ready[i]=1, out_valid[i] clears to 0 and out_data[i] holds its value.
  - Load and drain in the same cycle on the same channel: the old word leaves, the new word is stored, and out_valid stays 1. There is no bubble.
- Broadcast is all-or-nothing. No channel is loaded unless every channel is free.
- sel_err is registered. It is 1 in the cycle after an accept with in_bcast=0 and in_sel>=N, otherwise 0.
- xfer_count increments by 1 per accept and wraps from 16'hFFFF to 0. A broadcast counts as 1.
- out_ready[i] asserted while out_valid[i]=0 is ignored.
- The upstream must not change in_data, in_sel or in_bcast while in_valid=1 && in_ready=0. The block does not check this.

## Timing
- Reset values: out_valid=0, out_data=0, sel_err=0, xfer_count=0. in_ready follows its equation immediately; after reset it is 1.
- Reset asserted mid-operation discards all held words at once. No out_valid pulse follows deassertion.
- Latency: a word accepted at edge k has out_valid=1 after edge k; the earliest consumer take is at edge k+1.
- Throughput: 1 word per cycle per channel when the consumer holds out_ready=1.
- in_ready depends combinationally on out_ready, in_sel and in_bcast. There is no combinational path from in_valid to in_ready.

## Structure
- No shared package. SELW legality is checked at elaboration with a generate-time error when 2^SELW < N.
- Sub-module demux_stream_slot (WIDTH parameter): one-entry register with load, drain and free outputs. It is instantiated N times in a generate loop.
- The top level holds the select decode, broadcast AND, sel_err register and xfer_count.

## Test plan
- Sweep (N=8, WIDTH=1): drive in=1, sel=0..7 with all out_ready=1. Required: channel k shows out_valid=1, out_data=1 one cycle later; other channels stay 0; xfer_count=8.
- Stall isolation (WIDTH=8): hold out_ready[3]=0 and send 0xA5 to ch3, then 0x5A to ch3, then 0x11 to ch4. Required:
  - 0xA5 held on ch3.
  - in_ready=0 while 0x5A is presented.
  - ch4 unaffected; it still receives 0x11 once the 0x5A word is accepted.
  - When out_ready[3]=1, ch3 carries 0xA5 then 0x5A back-to-back.
- Broadcast: set in_bcast=1, in_data=0x3C with out_valid[6]=1 and out_ready[6]=0. Required: in_ready=0 and no channel loads. Releasing ch6 loads all 8 channels with 0x3C in one cycle.
- Out-of-range select (N=6, SELW=3): send sel=7. Required: accepted, sel_err=1 for one cycle, no out_valid change, xfer_count+1.
- Same-cycle load/drain: keep out_ready[2]=1 and stream 4 words to ch2. Required: out_valid[2] stays 1 for 4 consecutive cycles with the words in order.
- Reset mid-stream: assert reset with 3 channels full and xfer_count=0x0042. Required: immediate out_valid=0, xfer_count=0, sel_err=0. Wrap check: preload 0xFFFF accepts, then one more accept gives 0.
